dmem_lsu_ctrl: RTL and testbench

DMEM_LSU_CTRL -- requirements
Module: dmem_lsu_ctrl

---
 rtl/dmem_lsu_ctrl.sv | 171 +++++++++++++++++
 tb/tb_dmem_lsu_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu_ctrl.sv
// Load/store unit controller between the MEM stage and a single-port data memory.
// Issues one aligned word request per access, with a timeout, then aligns/extends load data.
module dmem_lsu_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_valid_i,
  input  logic        mem_we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        misalign_o,
  output logic        fault_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;

  logic        legal, aligned;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic        stall_c, misalign_c;

  // Decode the incoming access.
  always_comb begin
    legal     = 1'b0;
    aligned   = 1'b0;
    be_new    = 4'b1111;
    wdata_new = wdata_i;
    case (funct3_i)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = ~mem_we_i;
      default:                legal = 1'b0;
    endcase
    case (funct3_i[1:0])
      2'b00: begin
        aligned   = 1'b1;
        wdata_new = {4{wdata_i[7:0]}};
        if (mem_we_i) be_new = 4'b0001 << addr_i[1:0];
      end
      2'b01: begin
        aligned   = ~addr_i[0];
        wdata_new = {2{wdata_i[15:0]}};
        if (mem_we_i) be_new = 4'b0011 << addr_i[1:0];
      end
      default: aligned = (addr_i[1:0] == 2'b00);
    endcase
  end

  // Align and extend returned load data using the captured access.
  always_comb begin
    byte_sel = dmem_rdata_i[8*addr_q[1:0] +: 8];
    half_sel = addr_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (funct3_q)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_val = {24'h0, byte_sel};
      3'b101:  load_val = {16'h0, half_sel};
      default: load_val = dmem_rdata_i;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    fault_d    = 1'b0;
    stall_c    = 1'b0;
    misalign_c = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_valid_i) begin
          if (legal && aligned) begin
            we_d     = mem_we_i;
            funct3_d = funct3_i;
            addr_d   = addr_i;
            be_d     = be_new;
            wdata_d  = wdata_new;
            cnt_d    = 8'd0;
            stall_c  = 1'b1;
            state_d  = StBusy;
          end else begin
            misalign_c = 1'b1;
          end
        end
      end
      StBusy: begin
        stall_c = 1'b1;
        if (dmem_ack_i) begin
          if (!we_q) rdata_d = load_val;
          state_d = StResp;
        end else if (cnt_q == TimeoutLast) begin
          rdata_d = 32'h0;
          fault_d = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      funct3_q <= 3'b0;
      addr_q   <= 32'h0;
      be_q     <= 4'h0;
      wdata_q  <= 32'h0;
      cnt_q    <= 8'h0;
      rdata_q  <= 32'h0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      fault_q  <= fault_d;
    end
  end

  // Combinational IDLE outputs are masked so reset forces every output low.
  assign stall_o      = stall_c & reset_n;
  assign misalign_o   = misalign_c & reset_n;
  assign done_o       = (state_q == StResp);
  assign fault_o      = fault_q;
  assign rdata_o      = rdata_q;
  assign dmem_req_o   = (state_q == StBusy);
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = {addr_q[31:2], 2'b00};
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Self-checking bench for dmem_lsu_ctrl: directed vector table, reset corner case,
// then random accesses checked against a behavioural model.
module tb_dmem_lsu_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_valid_i, mem_we_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, done_o, misalign_o, fault_o;
  logic [31:0] rdata_o;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_lsu_ctrl #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mem_valid_i  (mem_valid_i),
    .mem_we_i     (mem_we_i),
    .funct3_i     (funct3_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .stall_o      (stall_o),
    .rdata_o      (rdata_o),
    .done_o       (done_o),
    .misalign_o   (misalign_o),
    .fault_o      (fault_o),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_be_o    (dmem_be_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_ack_i   (dmem_ack_i),
    .dmem_rdata_i (dmem_rdata_i)
  );

  typedef struct {
    bit        we;
    bit [2:0]  f3;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [31:0] rdata;
    int        ack_at;  // BUSY cycle carrying the ack; 0 = never
    bit        ok;
    bit [3:0]  be;
    bit [31:0] dw;
    bit [31:0] daddr;
    bit [31:0] rd;      // rdata_o expected after the access
    bit        fault;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Starts and ends just after a rising edge.
  task automatic run_access(input vec_t v);
    int n;
    mem_valid_i  = 1'b1;
    mem_we_i     = v.we;
    funct3_i     = v.f3;
    addr_i       = v.addr;
    wdata_i      = v.wdata;
    dmem_ack_i   = 1'b0;
    dmem_rdata_i = $urandom;
    @(negedge clk);
    chk("stall_issue", stall_o, v.ok);
    chk("misalign_issue", misalign_o, !v.ok);
    chk("req_issue", dmem_req_o, 0);
    @(posedge clk); #1;
    if (!v.ok) begin
      mem_valid_i = 1'b0;
      @(negedge clk);
      chk("req_after_misalign", dmem_req_o, 0);
      chk("misalign_one_pulse", misalign_o, 0);
      chk("done_after_misalign", done_o, 0);
      chk("rdata_hold_misalign", rdata_o, v.rd);
      @(posedge clk); #1;
      return;
    end
    n = 0;
    while (1) begin
      n++;
      dmem_ack_i   = (n == v.ack_at);
      dmem_rdata_i = (n == v.ack_at) ? v.rdata : $urandom;
      @(negedge clk);
      chk("req_busy", dmem_req_o, 1);
      chk("stall_busy", stall_o, 1);
      chk("done_busy", done_o, 0);
      chk("we_busy", dmem_we_o, v.we);
      chk("addr_busy", dmem_addr_o, v.daddr);
      chk("be_busy", dmem_be_o, v.be);
      if (v.we) chk("wdata_busy", dmem_wdata_o, v.dw);
      @(posedge clk); #1;
      if (n == v.ack_at || n >= TO) break;
    end
    dmem_ack_i   = 1'b1;  // must be ignored in RESP
    dmem_rdata_i = $urandom;
    @(negedge clk);
    chk("done_resp", done_o, 1);
    chk("fault_resp", fault_o, v.fault);
    chk("stall_resp", stall_o, 0);
    chk("req_resp", dmem_req_o, 0);
    chk("rdata_resp", rdata_o, v.rd);
    @(posedge clk); #1;
    mem_valid_i = 1'b0;
    dmem_ack_i  = 1'b0;
  endtask

  // Reference model: expected access behaviour from the load/store rules.
  function automatic vec_t model(input bit we, input bit [2:0] f3, input bit [31:0] a,
                                 input bit [31:0] wd, input bit [31:0] rd_in, input int ack_at,
                                 input bit [31:0] last_rd);
    vec_t v;
    int nbytes;
    bit [31:0] val, mask;
    v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rd_in; v.ack_at = ack_at;
    nbytes  = 1 << f3[1:0];
    v.ok    = (we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}))
              && ((a % nbytes) == 0);
    v.daddr = a - (a % 4);
    v.be    = we ? 4'(((1 << nbytes) - 1) << (a % 4)) : 4'hF;
    if (nbytes == 1)      v.dw = (wd & 32'hFF) * 32'h01010101;
    else if (nbytes == 2) v.dw = (wd & 32'hFFFF) * 32'h00010001;
    else                  v.dw = wd;
    v.fault = v.ok && (ack_at == 0);
    v.rd    = last_rd;
    if (v.fault) begin
      v.rd = 0;
    end else if (v.ok && !we) begin
      if (nbytes == 4) begin
        v.rd = rd_in;
      end else begin
        mask = (32'd1 << (8 * nbytes)) - 1;
        val  = (rd_in >> (8 * (a % 4))) & mask;
        if (!f3[2] && val >= (mask + 1) / 2) val = val - (mask + 1);
        v.rd = val;
      end
    end
    return v;
  endfunction

  initial begin
    vec_t vecs[14];
    vec_t v;
    bit [31:0] last_rd;

    vecs[0]  = '{0, 3'b000, 32'h103, 0, 32'h80123456, 2, 1, 4'hF, 0, 32'h100, 32'hFFFFFF80, 0};
    vecs[1]  = '{1, 3'b001, 32'h202, 32'h0000ABCD, 0, 1, 1, 4'hC, 32'hABCDABCD, 32'h200,
                 32'hFFFFFF80, 0};
    vecs[2]  = '{0, 3'b010, 32'h101, 0, 0, 1, 0, 0, 0, 0, 32'hFFFFFF80, 0};
    vecs[3]  = '{0, 3'b010, 32'h300, 0, 32'h55, 0, 1, 4'hF, 0, 32'h300, 32'h0, 1};
    vecs[4]  = '{0, 3'b101, 32'h2, 0, 32'hBEEF1234, 1, 1, 4'hF, 0, 32'h0, 32'h0000BEEF, 0};
    vecs[5]  = '{0, 3'b001, 32'h2, 0, 32'hBEEF1234, 1, 1, 4'hF, 0, 32'h0, 32'hFFFFBEEF, 0};
    vecs[6]  = '{1, 3'b000, 32'h7, 32'h123456A5, 0, 3, 1, 4'h8, 32'hA5A5A5A5, 32'h4,
                 32'hFFFFBEEF, 0};
    vecs[7]  = '{0, 3'b100, 32'h5, 0, 32'h11229933, 1, 1, 4'hF, 0, 32'h4, 32'h00000099, 0};
    vecs[8]  = '{0, 3'b011, 32'h8, 0, 0, 1, 0, 0, 0, 0, 32'h00000099, 0};
    vecs[9]  = '{1, 3'b100, 32'h8, 32'h1, 0, 1, 0, 0, 0, 0, 32'h00000099, 0};
    vecs[10] = '{1, 3'b010, 32'h10, 32'hDEADBEEF, 0, TO, 1, 4'hF, 32'hDEADBEEF, 32'h10,
                 32'h00000099, 0};
    vecs[11] = '{0, 3'b010, 32'h20, 0, 32'hCAFEF00D, 1, 1, 4'hF, 0, 32'h20, 32'hCAFEF00D, 0};
    vecs[12] = '{0, 3'b001, 32'h3, 0, 0, 1, 0, 0, 0, 0, 32'hCAFEF00D, 0};
    vecs[13] = '{1, 3'b000, 32'h1, 32'h77, 0, 0, 1, 4'h2, 32'h77777777, 32'h0, 32'h0, 1};

    reset_n = 1'b0; mem_valid_i = 1'b0; mem_we_i = 1'b0; funct3_i = 3'b0;
    addr_i = 32'h0; wdata_i = 32'h0; dmem_ack_i = 1'b0; dmem_rdata_i = 32'h0;
    #3;
    chk("rst_stall", stall_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_fault", fault_o, 0);
    chk("rst_req", dmem_req_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_be", dmem_be_o, 0);
    chk("rst_addr", dmem_addr_o, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    foreach (vecs[i]) run_access(vecs[i]);

    // Reset in the middle of BUSY, with a stray ack arriving afterwards.
    mem_valid_i = 1'b1; mem_we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h40;
    @(posedge clk); #1;
    @(negedge clk);
    chk("req_before_rst", dmem_req_o, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("req_drop_rst", dmem_req_o, 0);
    chk("stall_drop_rst", stall_o, 0);
    chk("rdata_clr_rst", rdata_o, 0);
    mem_valid_i = 1'b0;
    @(posedge clk); #1;
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'h12345678;
    reset_n = 1'b1;
    @(negedge clk);
    chk("req_after_rst", dmem_req_o, 0);
    @(posedge clk); #1;
    dmem_ack_i = 1'b0;
    @(negedge clk);
    chk("done_stray_ack", done_o, 0);
    chk("rdata_stray_ack", rdata_o, 0);
    @(posedge clk); #1;
    run_access('{1, 3'b010, 32'h10, 32'h0BADF00D, 0, 1, 1, 4'hF, 32'h0BADF00D, 32'h10, 32'h0, 0});

    last_rd = 32'h0;
    for (int k = 0; k < 200; k++) begin
      bit [31:0] a;
      a = $urandom_range(0, 255);
      v = model(1'($urandom), 3'($urandom), a, $urandom, $urandom,
                int'($urandom_range(0, TO)), last_rd);
      run_access(v);
      last_rd = v.rd;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
